up_counter_ctrl: RTL
====================

# up_counter_ctrl

Loadable up-counter with a programmable terminal value and a small run-control state machine. It is the counting-up companion to the team's `Down_counter` and uses the same clock and reset naming. It serves as the loop/timeout counter in datapath controllers, with a wrap mode for periodic ticks and a stop mode for one-shot runs. It uses one clock and a synchronous reset; all outputs are registered.

## Interface
- `WIDTH`, default 8: counter, load and limit width.
- `Clock`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `Clock`.
- `start`  in  1: begin counting (level sampled per edge).
- `en`  in  1: count enable; advances only in COUNT.
- `load`  in  1: parallel load of `D` into `Q`.
- `D`  in  WIDTH: load value.
- `limit`  in  WIDTH: terminal value; sampled every cycle, not latched.
- `wrap_mode`  in  1: 1 = wrap to 0 after terminal; 0 = stop in DONE.
- `Q`  out  WIDTH: current count.
- `busy`  out  1: high while state is COUNT.
- `tc`  out  1: one-cycle terminal-count pulse.
- `done`  out  1: high while state is DONE.

## Operation
- States are IDLE, COUNT and DONE.
- Reset (synchronous, highest priority) forces:
  - state to IDLE;
  - `Q` to 0;
  - `tc`, `busy` and `done` to 0.
- **IDLE**
  - `load` = 1: `Q` takes `D`.
  - `start` = 1: go to COUNT; `Q` is unchanged unless `load` is also 1.
  - `load` and `start` together: `Q` takes `D` and the state goes to COUNT.
  - `en` is ignored.
- **COUNT** (priority order):
  - `load` = 1: `Q` takes `D`; stay in COUNT; no `tc`.
  - `en` = 1 and `Q` == `limit`:
    - the `tc` pulse is generated;
    - `wrap_mode` = 1: `Q` goes to 0 and the state stays COUNT;
    - `wrap_mode` = 0: `Q` holds and the state goes to DONE.
  - `en` = 1 and `Q` != `limit`: `Q` becomes `Q`+1 modulo 2^WIDTH. For example, 8'hFF goes to 8'h00, which lets a count starting above `limit` wrap around and reach it.
  - `en` = 0: hold.
  - `start` is ignored.
- **DONE**
  - `load` = 1: `Q` takes `D`; go to IDLE. `load` has priority over `start`.
  - `start` = 1: `Q` goes to 0; go to COUNT.
  - Otherwise `Q` holds.
- Reset asserted in any state, including mid-count or during a `tc` cycle, aborts the run with no pending pulse.
- Equality compare is full WIDTH.
- `limit` = 0 with `wrap_mode` = 1 gives a `tc` pulse on every enabled cycle, with `Q` held at 0.
- Changing `limit` mid-run takes effect on the next compare.

## Timing
- Outputs are registered, with zero combinational input-to-output paths.
- `Q` reflects load or increment one edge after the qualifying inputs are sampled.
- `tc` is high exactly for the cycle after the edge at which the terminal condition (COUNT, `en`, `Q` == `limit`, no `load`) was sampled. In that same cycle:
  - `Q` shows 0 (wrap mode) or `limit` (stop mode);
  - `done` is high (stop mode only).
- `busy` rises the cycle after `start` is accepted. In stop mode it falls in the same cycle that `done` rises.
- Back-to-back terminal events in wrap mode give `tc` pulses separated by `limit`+1 enabled cycles.
- Start-to-`tc` latency from `Q` = 0 with `en` held at 1: `limit`+1 edges after the COUNT-entry edge.

## Test plan
- Reset check: assert `reset` for 2 cycles with random inputs, then release with inputs at 0 → `Q`=0, `busy`=`done`=`tc`=0 throughout.
- Stop mode:
  - stimulus: `load` `D`=3 in IDLE, then `start`, `limit`=7, `en`=1, `wrap_mode`=0;
  - required: `Q` steps 3,4,5,6,7; one `tc` pulse; `done`=1 with `Q` held at 7;
  - follow-up: `start` → `Q`=0, `busy`=1.
- Wrap mode:
  - stimulus: `limit`=2, `wrap_mode`=1, `en`=1 from `Q`=0;
  - required: `Q` sequence 0,1,2,0,1,2…; `tc` high on every cycle where `Q` returns to 0; `busy` stays 1.
- Wrap-around:
  - stimulus: `load` 8'hFE, `start`, `limit`=1, `wrap_mode`=0;
  - required: `Q` goes FE,FF,00,01 → `done`; exactly one `tc`.
- Priority and gating:
  - in COUNT, assert `load`=1, `D`=5 and `en`=1 while `Q`==`limit` → `Q`=5, no `tc`, state stays COUNT;
  - with `en`=0 for 4 cycles, `Q` holds.
- Mid-run reset: assert `reset` while `Q`=4 and `busy`=1 → next cycle `Q`=0, state IDLE, no `tc`.

Source files
------------

// File: rtl/up_counter_ctrl.sv
// Loadable up-counter with programmable terminal value, wrap/stop run modes
// and an IDLE/COUNT/DONE run-control state machine. All outputs registered.
module up_counter_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] limit,
    input  logic             wrap_mode,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    // busy/done are registered copies of the state decode, updated together with state
    always_ff @(posedge Clock) begin
        if (reset) begin
            state <= IDLE;
            Q     <= '0;
            busy  <= 1'b0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        Q <= D;
                    end
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end

                COUNT: begin
                    if (load) begin
                        Q <= D;
                    end else if (en) begin
                        if (Q == limit) begin
                            tc <= 1'b1;
                            if (wrap_mode) begin
                                Q <= '0;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            Q <= Q + WIDTH'(1);
                        end
                    end
                end

                DONE: begin
                    // load wins over start and returns to IDLE
                    if (load) begin
                        Q     <= D;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (start) begin
                        Q     <= '0;
                        state <= COUNT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    Q     <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
